ucie_d2d_retry_buffer: RTL and testbench

- Transmit-side Link-Level Retry (LLR) buffer between the D2D adapter's flit TX output and the physical layer's TX flit input.
- Tags each outgoing flit with a sequence number and holds it until the remote die acknowledges it.
- Replays unacknowledged flits on NAK.
- Escalates to a link-error state when replays repeat without forward progress.

---
 rtl/ucie_d2d_retry_buffer_if.sv | 28 ++
 rtl/ucie_d2d_retry_buffer.sv | 182 ++++++++++++++++++
 tb/tb_ucie_d2d_retry_buffer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ucie_d2d_retry_buffer_if.sv
// Flit and ACK/NAK bundle around the UCIe D2D link-level retry buffer.
// The slave modport is the buffer; the master modport is the adapter/PHY side.
interface ucie_d2d_retry_buffer_if #(
    parameter int FLIT_WIDTH = 256,
    parameter int SEQ_WIDTH  = 8
);
    logic [FLIT_WIDTH-1:0] in_flit;
    logic                  in_valid;
    logic                  in_ready;
    logic [FLIT_WIDTH-1:0] out_flit;
    logic [SEQ_WIDTH-1:0]  out_seq;
    logic                  out_valid;
    logic                  out_ready;
    logic                  ack_valid;
    logic [SEQ_WIDTH-1:0]  ack_seq;
    logic                  nak_valid;
    logic [SEQ_WIDTH-1:0]  nak_seq;

    modport master (
        output in_flit, in_valid, out_ready, ack_valid, ack_seq, nak_valid, nak_seq,
        input  in_ready, out_flit, out_seq, out_valid
    );

    modport slave (
        input  in_flit, in_valid, out_ready, ack_valid, ack_seq, nak_valid, nak_seq,
        output in_ready, out_flit, out_seq, out_valid
    );
endinterface

// File: rtl/ucie_d2d_retry_buffer.sv
// Transmit-side link-level retry buffer: sequence tagging, ACK release, NAK replay, error escalation.
// Optional replay timer is compiled in with `define UCIE_RETRY_TIMEOUT_EN.
module ucie_d2d_retry_buffer #(
    parameter int FLIT_WIDTH     = 256,
    parameter int DEPTH          = 16,
    parameter int SEQ_WIDTH      = 8,
    parameter int MAX_REPLAY     = 3,
    parameter int REPLAY_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ucie_d2d_retry_buffer_if.slave bus,
    input  logic                   retrain_clear,
    output logic                   replay_active,
    output logic                   link_error,
    output logic                   protocol_err,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAX_REPLAY + 2);
    localparam logic [PW-1:0]        P_ONE = PW'(1);
    localparam logic [SEQ_WIDTH-1:0] S_ONE = SEQ_WIDTH'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || (2 ** SEQ_WIDTH) <= DEPTH ||
        MAX_REPLAY < 1 || REPLAY_TIMEOUT < 1) begin : g_param_check
        $error("ucie_d2d_retry_buffer: illegal parameter set");
    end

    typedef enum logic [1:0] {NORMAL, REPLAY, ERROR} state_t;

    state_t                state, state_nxt;
    logic [PW-1:0]         head, head_nxt, send, send_nxt, tail, tail_nxt;
    logic [PW-1:0]         replay_end, replay_end_nxt, occ, sent_cnt, send_adv;
    logic [SEQ_WIDTH-1:0]  next_seq, next_seq_nxt, head_seq;
    logic [SEQ_WIDTH-1:0]  nak_seq_eff, nak_off, ack_off;
    logic [CW-1:0]         replay_cnt, replay_cnt_nxt;
    logic                  perr_nxt, in_rdy, out_vld, wr, rd;
    logic                  nak_fire, nak_ok, ack_fire, ack_ok, ack_prog, timeout_hit;

    logic [FLIT_WIDTH-1:0] flit_mem [DEPTH];
    logic [SEQ_WIDTH-1:0]  seq_mem  [DEPTH];
    logic [FLIT_WIDTH-1:0] out_flit_p0, flit_nxt;
    logic [SEQ_WIDTH-1:0]  out_seq_p0, seq_nxt;

    // Distance of a sequence number past the oldest unacked one, modulo the sequence space.
    function automatic logic [SEQ_WIDTH-1:0] seq_dist(input logic [SEQ_WIDTH-1:0] seq,
                                                      input logic [SEQ_WIDTH-1:0] base);
        return seq - base;
    endfunction

    assign occ      = tail - head;
    assign sent_cnt = send - head;
    assign head_seq = next_seq - SEQ_WIDTH'(occ);
    assign in_rdy   = (state == NORMAL) && (occ < PW'(DEPTH));
    assign out_vld  = ((state == NORMAL) && (send != tail)) ||
                      ((state == REPLAY) && (send != replay_end));
    assign wr       = bus.in_valid && in_rdy;
    assign rd       = out_vld && bus.out_ready;
    assign send_adv = rd ? send + P_ONE : send;

    assign nak_fire    = (bus.nak_valid || timeout_hit) && (state != ERROR);
    assign nak_seq_eff = bus.nak_valid ? bus.nak_seq : head_seq;
    assign nak_off     = seq_dist(nak_seq_eff, head_seq);
    assign nak_ok      = nak_off <= SEQ_WIDTH'(sent_cnt);
    assign ack_fire    = bus.ack_valid && !nak_fire && (state != ERROR);
    assign ack_off     = seq_dist(bus.ack_seq, head_seq);
    assign ack_ok      = ack_off < SEQ_WIDTH'(sent_cnt);
    assign ack_prog    = ack_fire && ack_ok;

    always_comb begin
        state_nxt      = state;
        head_nxt       = head;
        send_nxt       = send_adv;
        tail_nxt       = wr ? tail + P_ONE : tail;
        next_seq_nxt   = wr ? next_seq + S_ONE : next_seq;
        replay_end_nxt = replay_end;
        replay_cnt_nxt = replay_cnt;
        perr_nxt       = 1'b0;
        if (state == REPLAY && send == replay_end)
            state_nxt = NORMAL;
        if (nak_fire) begin
            if (nak_ok) begin
                // Flits before nak_seq are implicitly acknowledged; replay up to what was sent.
                head_nxt       = head + PW'(nak_off);
                send_nxt       = head + PW'(nak_off);
                replay_end_nxt = send_adv;
                replay_cnt_nxt = replay_cnt + CW'(1);
                state_nxt      = (replay_cnt == CW'(MAX_REPLAY)) ? ERROR : REPLAY;
            end else begin
                perr_nxt = 1'b1;
            end
        end else if (ack_fire) begin
            if (ack_ok) begin
                head_nxt       = head + PW'(ack_off) + P_ONE;
                replay_cnt_nxt = '0;
            end else begin
                perr_nxt = 1'b1;
            end
        end
        if (retrain_clear) begin
            state_nxt      = NORMAL;
            head_nxt       = '0;
            send_nxt       = '0;
            tail_nxt       = '0;
            next_seq_nxt   = '0;
            replay_end_nxt = '0;
            replay_cnt_nxt = '0;
            perr_nxt       = 1'b0;
        end
    end

    // A flit written this edge can be presented straight away, hence the bypass.
    always_comb begin
        flit_nxt = flit_mem[send_nxt[AW-1:0]];
        seq_nxt  = seq_mem[send_nxt[AW-1:0]];
        if (wr && send_nxt == tail) begin
            flit_nxt = bus.in_flit;
            seq_nxt  = next_seq;
        end
    end

    always_ff @(posedge clk) begin
        if (wr && !retrain_clear) begin
            flit_mem[tail[AW-1:0]] <= bus.in_flit;
            seq_mem[tail[AW-1:0]]  <= next_seq;
        end
    end

    // ---- output stage p0 ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= NORMAL;
            head         <= '0;
            send         <= '0;
            tail         <= '0;
            next_seq     <= '0;
            replay_end   <= '0;
            replay_cnt   <= '0;
            protocol_err <= 1'b0;
            out_flit_p0  <= '0;
            out_seq_p0   <= '0;
        end else begin
            state        <= state_nxt;
            head         <= head_nxt;
            send         <= send_nxt;
            tail         <= tail_nxt;
            next_seq     <= next_seq_nxt;
            replay_end   <= replay_end_nxt;
            replay_cnt   <= replay_cnt_nxt;
            protocol_err <= perr_nxt;
            out_flit_p0  <= retrain_clear ? '0 : flit_nxt;
            out_seq_p0   <= retrain_clear ? '0 : seq_nxt;
        end
    end

`ifdef UCIE_RETRY_TIMEOUT_EN
    localparam int TW = $clog2(REPLAY_TIMEOUT + 1);
    logic [TW-1:0] timer;

    assign timeout_hit = (state == NORMAL) && (timer == TW'(REPLAY_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            timer <= '0;
        else if (retrain_clear || ack_prog || nak_fire || occ == '0 || state != NORMAL)
            timer <= '0;
        else
            timer <= timer + TW'(1);
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_flit  = out_flit_p0;
    assign bus.out_seq   = out_seq_p0;
    assign replay_active = (state == REPLAY);
    assign link_error    = (state == ERROR);
    assign occupancy     = occ;
endmodule

// File: tb/tb_ucie_d2d_retry_buffer.sv
// Randomized bench for ucie_d2d_retry_buffer against a queue-based reference model.
module tb_ucie_d2d_retry_buffer;
    localparam int FW = 256;
    localparam int DEPTH = 16;
    localparam int SW = 8;
    localparam int MAX_REPLAY = 3;
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int M_NORM = 0, M_RPL = 1, M_ERR = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          retrain_clear = 1'b0;
    logic          replay_active, link_error, protocol_err;
    logic [PW-1:0] occupancy;

    ucie_d2d_retry_buffer_if #(.FLIT_WIDTH(FW), .SEQ_WIDTH(SW)) bus ();

    ucie_d2d_retry_buffer #(
        .FLIT_WIDTH(FW), .DEPTH(DEPTH), .SEQ_WIDTH(SW),
        .MAX_REPLAY(MAX_REPLAY), .REPLAY_TIMEOUT(1024)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .retrain_clear(retrain_clear),
        .replay_active(replay_active), .link_error(link_error),
        .protocol_err(protocol_err), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: the unacknowledged flits in order, how many of them the PHY has taken,
    // and (while replaying) how far the replay reaches.
    typedef struct {
        logic [SW-1:0] seq;
        logic [FW-1:0] data;
    } ent_t;
    ent_t          q[$];
    int            m_sent, m_rend, m_rcnt, m_mode;
    logic [SW-1:0] m_next;
    logic          m_perr;

    function automatic void model_reset();
        q.delete();
        m_sent = 0; m_rend = 0; m_rcnt = 0; m_mode = M_NORM; m_next = '0; m_perr = 1'b0;
    endfunction

    function automatic logic m_in_ready();
        return (m_mode == M_NORM) && (q.size() < DEPTH);
    endfunction

    function automatic logic m_out_valid();
        if (m_mode == M_NORM) return m_sent < q.size();
        if (m_mode == M_RPL)  return m_sent < m_rend;
        return 1'b0;
    endfunction

    function automatic logic [SW-1:0] m_front();
        return m_next - SW'(q.size());
    endfunction

    task automatic compare_all();
        check("in_ready", FW'(bus.in_ready), FW'(m_in_ready()));
        check("out_valid", FW'(bus.out_valid), FW'(m_out_valid()));
        if (m_out_valid()) begin
            check("out_seq", FW'(bus.out_seq), FW'(q[m_sent].seq));
            check("out_flit", bus.out_flit, q[m_sent].data);
        end
        check("occupancy", FW'(occupancy), FW'(q.size()));
        check("replay_active", FW'(replay_active), FW'(m_mode == M_RPL));
        check("link_error", FW'(link_error), FW'(m_mode == M_ERR));
        check("protocol_err", FW'(protocol_err), FW'(m_perr));
    endtask

    // One clock: drive at the falling edge, advance the model at the rising edge, compare after it.
    task automatic step(input logic iv, input logic orr, input logic av, input logic [SW-1:0] as,
                        input logic nv, input logic [SW-1:0] ns, input logic rc);
        logic [FW-1:0] d;
        logic [SW-1:0] front, off;
        logic          wr, rd;
        int            k, adv;
        for (int i = 0; i < FW / 32; i++) d[i*32 +: 32] = $urandom();
        bus.in_valid = iv; bus.in_flit = d; bus.out_ready = orr;
        bus.ack_valid = av; bus.ack_seq = as; bus.nak_valid = nv; bus.nak_seq = ns;
        retrain_clear = rc;
        wr = iv && m_in_ready();
        rd = orr && m_out_valid();
        @(posedge clk);
        if (rc) begin
            model_reset();
        end else begin
            front  = m_front();
            adv    = m_sent + (rd ? 1 : 0);
            m_perr = 1'b0;
            if (m_mode == M_RPL && m_sent == m_rend) m_mode = M_NORM;
            if (nv && m_mode != M_ERR) begin
                off = ns - front; k = int'(off);
                if (k <= m_sent) begin
                    repeat (k) void'(q.pop_front());
                    m_rend = adv - k; m_sent = 0; m_rcnt++;
                    m_mode = (m_rcnt == MAX_REPLAY + 1) ? M_ERR : M_RPL;
                end else begin
                    m_perr = 1'b1; m_sent = adv;
                end
            end else if (av && m_mode != M_ERR) begin
                off = as - front; k = int'(off);
                if (k < m_sent) begin
                    repeat (k + 1) void'(q.pop_front());
                    m_sent = adv - (k + 1); m_rend = m_rend - (k + 1); m_rcnt = 0;
                end else begin
                    m_perr = 1'b1; m_sent = adv;
                end
            end else begin
                m_sent = adv;
            end
            if (wr) begin
                q.push_back('{seq: m_next, data: d});
                m_next = m_next + SW'(1);
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input logic orr);
        step(1'b0, orr, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic retrain();
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] occ_before;
        logic          perr_any, saw_wrap;
        logic [SW-1:0] prev_seq, as, ns;
        logic          iv, orr, av, nv, rc;
        int            written;

        bus.in_valid = 1'b0; bus.in_flit = '0; bus.out_ready = 1'b0;
        bus.ack_valid = 1'b0; bus.ack_seq = '0; bus.nak_valid = 1'b0; bus.nak_seq = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compare_all();
        check("rst_out_flit", bus.out_flit, '0);
        check("rst_out_seq", FW'(bus.out_seq), '0);

        // Basic flow: each flit appears the cycle after it is written.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
            check("basic_seq", FW'(bus.out_seq), FW'(i));
            check("basic_valid", FW'(bus.out_valid), FW'(1));
        end
        idle(1'b1);
        step(1'b0, 1'b1, 1'b1, SW'(3), 1'b0, '0, 1'b0);
        check("basic_ack_occ", FW'(occupancy), '0);

        // Full buffer, then release two entries.
        retrain();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        idle(1'b1);
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        check("full_occ", FW'(occupancy), FW'(16));
        check("full_ready", FW'(bus.in_ready), '0);
        step(1'b1, 1'b1, 1'b1, SW'(1), 1'b0, '0, 1'b0);
        check("full_ack_occ", FW'(occupancy), FW'(14));
        check("full_ack_ready", FW'(bus.in_ready), FW'(1));

        // Replay from seq 2 after sending 0..5.
        retrain();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        idle(1'b1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1, SW'(2), 1'b0);
        check("rpl_active", FW'(replay_active), FW'(1));
        check("rpl_occ", FW'(occupancy), FW'(4));
        for (int s = 2; s < 6; s++) begin
            check("rpl_seq", FW'(bus.out_seq), FW'(s));
            idle(1'b1);
        end
        for (int t = 0; t < 8 && replay_active; t++) idle(1'b1);
        check("rpl_done", FW'(replay_active), '0);
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        check("rpl_resume_seq", FW'(bus.out_seq), FW'(6));

        // Four NAKs of seq 0 without progress escalate to link error.
        retrain();
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        idle(1'b1);
        for (int n = 0; n < 4; n++) step(1'b0, 1'b0, 1'b0, '0, 1'b1, '0, 1'b0);
        check("esc_link_error", FW'(link_error), FW'(1));
        check("esc_out_valid", FW'(bus.out_valid), '0);
        retrain();
        check("esc_clear_occ", FW'(occupancy), '0);
        check("esc_clear_err", FW'(link_error), '0);
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        check("esc_first_seq", FW'(bus.out_seq), '0);

        // Sequence wrap with periodic ACKs, then a stale ACK.
        retrain();
        written = 0; perr_any = 1'b0; saw_wrap = 1'b0; prev_seq = '0;
        for (int c = 0; c < 700 && written < 300; c++) begin
            av = (c % 8 == 7) && (m_sent > 0);
            as = m_front() + SW'(m_sent) - SW'(1);
            if (m_in_ready()) written++;
            step(1'b1, 1'b1, av, as, 1'b0, '0, 1'b0);
            perr_any |= protocol_err;
            if (bus.out_valid) begin
                if (prev_seq == SW'(255) && bus.out_seq == '0) saw_wrap = 1'b1;
                prev_seq = bus.out_seq;
            end
        end
        check("wrap_written", FW'(written), FW'(300));
        check("wrap_seen", FW'(saw_wrap), FW'(1));
        check("wrap_no_perr", FW'(perr_any), '0);
        idle(1'b1);
        occ_before = occupancy;
        step(1'b0, 1'b1, 1'b1, SW'(200), 1'b0, '0, 1'b0);
        check("stale_perr", FW'(protocol_err), FW'(1));
        check("stale_occ", FW'(occupancy), FW'(occ_before));
        idle(1'b1);
        check("stale_pulse_end", FW'(protocol_err), '0);

        // ACK and NAK together: only the NAK acts.
        retrain();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        idle(1'b1);
        step(1'b0, 1'b0, 1'b1, SW'(3), 1'b1, SW'(1), 1'b0);
        check("coll_occ", FW'(occupancy), FW'(3));
        check("coll_replay", FW'(replay_active), FW'(1));
        check("coll_perr", FW'(protocol_err), '0);

        // Randomized traffic with near-window and arbitrary ACK/NAK sequence numbers.
        for (int c = 0; c < 3000; c++) begin
            iv  = ($urandom_range(0, 9) < 7);
            orr = ($urandom_range(0, 9) < 7);
            av  = ($urandom_range(0, 99) < 12);
            nv  = ($urandom_range(0, 99) < 4);
            as  = m_front() + SW'($urandom_range(0, q.size())) - SW'(1);
            ns  = m_front() + SW'($urandom_range(0, m_sent + 1));
            if ($urandom_range(0, 19) == 0) as = SW'($urandom());
            if ($urandom_range(0, 19) == 0) ns = SW'($urandom());
            rc  = (m_mode == M_ERR) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 499) == 0);
            step(iv, orr, av, as, nv, ns, rc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
